mdu_hilo: RTL and testbench
===========================

# mdu_hilo

Multi-cycle multiply/divide unit that produces the HI/LO values carried down the pipeline as the HILO result. It sits in the E stage. It accepts MIPS `mult`/`multu`/`div`/`divu`/`mthi`/`mtlo` requests and holds the HI/LO architectural registers. It reports `busy` so the hazard unit can stall HILO-dependent instructions. `hi`/`lo` are read combinationally by E and forwarded downstream.

## Interface
- `MULT_CYCLES`, 5, busy cycles for `mult`/`multu` (≥1)
- `DIV_CYCLES`, 10, busy cycles for `div`/`divu` (≥1)
- `clk` input 1: sole clock, rising edge
- `rst_n` input 1: asynchronous, active-low reset
- `start` input 1: request valid this cycle
- `cancel` input 1: pipeline flush/exception in E; suppresses a same-cycle `start`
- `op` input 3: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6–7 reserved (no-op)
- `a` input 32: rs operand / dividend / MTHI-MTLO data
- `b` input 32: rt operand / divisor
- `busy` output 1: operation in flight
- `hi` output 32: HI register
- `lo` output 32: LO register

## Operation
- States: IDLE, RUN. `busy` = (state == RUN), registered.
- Request accepted when `start && !cancel && state == IDLE`. If `start` arrives while RUN, it is ignored. The hazard unit guarantees stall, but the block must not rely on that.
- Accepted MULT/MULTU/DIV/DIVU:
  - Latch op, `a`, `b`.
  - Load the counter with MULT_CYCLES or DIV_CYCLES; go to RUN.
- Accepted MTHI/MTLO:
  - Write `a` into `hi`/`lo` at that edge; remain IDLE.
  - Zero latency; `busy` stays 0.
- Reserved op codes: no state change.
- RUN:
  - Counter decrements each edge.
  - On the edge where the counter reaches zero, commit the result to `hi`/`lo` and return to IDLE.
- MULT: {hi,lo} = signed(a) × signed(b), 64-bit two's complement.
- MULTU: {hi,lo} = unsigned 64-bit product.
- DIV (signed):
  - lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- DIVU: unsigned quotient → lo, remainder → hi.
- Divide by zero: timing is unchanged (full DIV_CYCLES busy), and `hi`/`lo` are left unchanged at commit.
- Result computation may be combinational at start, or iterative. Only commit timing and values are specified.
- `cancel` does not abort an op already in RUN. An accepted op always commits.

## Timing
- Reset (`rst_n` low, asynchronous): state=IDLE, counter=0, `busy`=0, `hi`=0, `lo`=0, latched operands=0. Reset asserted mid-RUN aborts immediately with no commit.
- Start accepted at edge E0:
  - `busy` = 1 from after E0 until edge E0+N, where N = MULT_CYCLES or DIV_CYCLES. That is exactly N cycles high.
  - `hi`/`lo` update at E0+N, at the same edge `busy` falls.
- A new start is accepted in the first cycle `busy` is 0. Back-to-back ops therefore have no gap.
- MTHI/MTLO: `hi`/`lo` are visible in the cycle after the accepting edge.
- `hi`/`lo` are stable throughout RUN and hold their old values until commit.

## Test plan
- Reset, then MULT a=0xFFFFFFFE (−2), b=3 at edge 0 → `busy`=1 for cycles 1–5; after edge 5, hi=0xFFFFFFFF, lo=0xFFFFFFFA, `busy`=0.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → after 5 cycles hi=0xFFFFFFFE, lo=0x00000001.
- DIV a=0xFFFFFFF9 (−7), b=2 → `busy` for 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then DIVU a=7, b=0 → hi/lo unchanged after 10 busy cycles.
- MTHI a=0x12345678, then MTLO a=0x9ABCDEF0 on consecutive cycles → hi/lo updated one cycle each, `busy` never asserts. A `start` of MULT issued while `busy` is ignored, with a single commit.
- `start`+`cancel` together with MULT → no state change, `busy` stays 0. `cancel` pulsed mid-RUN → the op still commits normally.
- Start DIV, pull `rst_n` low at cycle 4 → `busy`, hi, and lo go to 0 immediately. After release, no late commit occurs.

Source files
------------

// File: rtl/mdu_hilo.sv
// mdu_hilo: multi-cycle multiply/divide unit holding the MIPS HI/LO registers.
// Operands are latched when an op is accepted. The result is formed
// combinationally from the latched operands and written to HI/LO only on the
// final busy cycle, so HI/LO keep their old values for the whole run.
module mdu_hilo #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        cancel,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] MULT_N = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_N  = CW'(DIV_CYCLES);
    localparam logic [CW-1:0] ONE    = CW'(1);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [2:0]      op_q;
    logic [31:0]     a_q, b_q;

    logic [63:0]     prod_s, prod_u;
    logic            div_ovf;
    logic [31:0]     dvs_s, dvs_u;
    logic [31:0]     quo_s, rem_s, quo_u, rem_u;
    logic [31:0]     res_hi, res_lo;

    // Products on sign-/zero-extended 64-bit operands.
    assign prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
    assign prod_u = {32'b0, a_q} * {32'b0, b_q};

    // Divisor is forced to 1 for divide-by-zero (result discarded anyway) and
    // for INT_MIN / -1, where dividing by 1 yields exactly the required
    // quotient 0x80000000 and remainder 0 without signed overflow.
    assign div_ovf = (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);
    assign dvs_s   = (b_q == '0 || div_ovf) ? 32'd1 : b_q;
    assign dvs_u   = (b_q == '0) ? 32'd1 : b_q;
    assign quo_s   = $signed(a_q) / $signed(dvs_s);
    assign rem_s   = $signed(a_q) % $signed(dvs_s);
    assign quo_u   = a_q / dvs_u;
    assign rem_u   = a_q % dvs_u;

    // Value HI/LO take at commit; divide-by-zero leaves them untouched.
    always_comb begin
        res_hi = hi;
        res_lo = lo;
        case (op_q)
            OP_MULT:  {res_hi, res_lo} = prod_s;
            OP_MULTU: {res_hi, res_lo} = prod_u;
            OP_DIV:   if (b_q != '0) begin res_hi = rem_s; res_lo = quo_s; end
            OP_DIVU:  if (b_q != '0) begin res_hi = rem_u; res_lo = quo_u; end
            default:  ;
        endcase
    end

    // Control FSM, operand latches and HI/LO registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !cancel) begin
                        case (op)
                            OP_MULT, OP_MULTU: begin
                                op_q  <= op;
                                a_q   <= a;
                                b_q   <= b;
                                cnt   <= MULT_N;
                                state <= RUN;
                                busy  <= 1'b1;
                            end
                            OP_DIV, OP_DIVU: begin
                                op_q  <= op;
                                a_q   <= a;
                                b_q   <= b;
                                cnt   <= DIV_N;
                                state <= RUN;
                                busy  <= 1'b1;
                            end
                            OP_MTHI: hi <= a;
                            OP_MTLO: lo <= a;
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    // Starts arriving here are dropped; cancel cannot abort.
                    cnt <= cnt - ONE;
                    if (cnt == ONE) begin
                        hi    <= res_hi;
                        lo    <= res_lo;
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mdu_hilo.sv
// tb_mdu_hilo: randomized and directed checks of mdu_hilo against a
// behavioural HI/LO model using plain 64-bit arithmetic.
module tb_mdu_hilo;
    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk, rst_n, start, cancel;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        busy;
    logic [31:0] hi, lo;

    int n_chk  = 0;
    int n_fail = 0;
    logic [31:0] m_hi, m_lo;

    mdu_hilo #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cancel(cancel),
        .op(op), .a(a), .b(b), .busy(busy), .hi(hi), .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Architectural effect of a completed op on HI/LO.
    task automatic model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] nhi, output logic [31:0] nlo);
        longint sx, sy, q, r, p;
        longint unsigned ux, uy, up;
        nhi = m_hi;
        nlo = m_lo;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'b0, x};
        uy = {32'b0, y};
        case (o)
            3'd0: begin p = sx * sy; nhi = p[63:32]; nlo = p[31:0]; end
            3'd1: begin up = ux * uy; nhi = up[63:32]; nlo = up[31:0]; end
            3'd2: if (y != 0) begin
                q = (sx < 0 ? -sx : sx) / (sy < 0 ? -sy : sy);
                if ((sx < 0) != (sy < 0)) q = -q;
                r = sx - q * sy;
                nlo = q[31:0];
                nhi = r[31:0];
            end
            3'd3: if (y != 0) begin nlo = 32'(ux / uy); nhi = 32'(ux % uy); end
            3'd4: nhi = x;
            3'd5: nlo = x;
            default: ;
        endcase
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; cancel = 1'b0; op = '0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        n_chk++;
        if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
            n_fail++;
            $display("FAIL reset busy=%b hi=%h lo=%h want 0/0/0", busy, hi, lo);
        end
        rst_n = 1'b1;
        m_hi = '0; m_lo = '0;
        @(posedge clk); #1;
    endtask

    // Runs n mult/div ops; directed ones come from the test-plan table.
    // With b2b set the next start is raised in the first non-busy cycle.
    task automatic test_arith(input int n, input bit directed, input bit b2b);
        logic [2:0]  d_op [5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd2};
        logic [31:0] d_a  [5] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'd7, 32'h80000000};
        logic [31:0] d_b  [5] = '{32'd3, 32'hFFFFFFFF, 32'd2, 32'd0, 32'hFFFFFFFF};
        logic [2:0]  xo;
        logic [31:0] xa, xb, ehi, elo;
        int nc;
        for (int t = 0; t < n; t++) begin
            if (directed) begin
                xo = d_op[t]; xa = d_a[t]; xb = d_b[t];
            end else begin
                xo = 3'($urandom_range(0, 3));
                xa = $urandom;
                xb = $urandom;
                if ($urandom_range(0, 3) == 0) xb = 32'($urandom_range(0, 9));
                if ($urandom_range(0, 3) == 0) xa = 32'($urandom_range(0, 99));
                if ($urandom_range(0, 5) == 0) xb = 32'hFFFFFFFF - 32'($urandom_range(0, 3));
            end
            model(xo, xa, xb, ehi, elo);
            start = 1'b1; op = xo; a = xa; b = xb;
            @(posedge clk); #1;
            start = 1'b0; a = $urandom; b = $urandom;
            nc = (xo < 3'd2) ? MC : DC;
            for (int c = 0; c < nc; c++) begin
                if (c > 0) begin @(posedge clk); #1; end
                n_chk++;
                if (busy !== 1'b1 || hi !== m_hi || lo !== m_lo) begin
                    n_fail++;
                    $display("FAIL run op=%0d cyc=%0d busy=%b hi=%h lo=%h want 1 %h %h",
                             xo, c, busy, hi, lo, m_hi, m_lo);
                end
            end
            @(posedge clk); #1;
            n_chk++;
            if (busy !== 1'b0 || hi !== ehi || lo !== elo) begin
                n_fail++;
                $display("FAIL commit op=%0d a=%h b=%h busy=%b hi=%h lo=%h want 0 %h %h",
                         xo, xa, xb, busy, hi, lo, ehi, elo);
            end
            m_hi = ehi; m_lo = elo;
            if (!b2b) begin @(posedge clk); #1; end
        end
    endtask

    task automatic test_mthi_mtlo();
        logic [31:0] ehi, elo;
        start = 1'b1; op = 3'd4; a = 32'h12345678;
        model(op, a, 32'h0, ehi, elo);
        @(posedge clk); #1;
        m_hi = ehi;
        n_chk++;
        if (busy !== 1'b0 || hi !== 32'h12345678 || lo !== m_lo) begin
            n_fail++;
            $display("FAIL mthi busy=%b hi=%h lo=%h want 0 12345678 %h", busy, hi, lo, m_lo);
        end
        op = 3'd5; a = 32'h9ABCDEF0;
        model(op, a, 32'h0, ehi, elo);
        @(posedge clk); #1;
        m_lo = elo;
        n_chk++;
        if (busy !== 1'b0 || hi !== 32'h12345678 || lo !== 32'h9ABCDEF0) begin
            n_fail++;
            $display("FAIL mtlo busy=%b hi=%h lo=%h want 0 12345678 9abcdef0", busy, hi, lo);
        end
        // Reserved op codes must leave everything alone.
        for (int r = 6; r < 8; r++) begin
            op = 3'(r); a = $urandom; b = $urandom;
            @(posedge clk); #1;
            n_chk++;
            if (busy !== 1'b0 || hi !== m_hi || lo !== m_lo) begin
                n_fail++;
                $display("FAIL reserved op=%0d busy=%b hi=%h lo=%h want 0 %h %h",
                         r, busy, hi, lo, m_hi, m_lo);
            end
        end
        start = 1'b0;
        @(posedge clk); #1;
    endtask

    // A MULT start raised mid-run is dropped: one commit, then idle.
    task automatic test_ignored_start();
        logic [31:0] ehi, elo;
        model(3'd1, 32'd1000, 32'd3000, ehi, elo);
        start = 1'b1; op = 3'd1; a = 32'd1000; b = 32'd3000;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; op = 3'd0; a = 32'hFFFFFFFF; b = 32'd7;
        @(posedge clk); #1;
        n_chk++;
        if (busy !== 1'b1 || hi !== m_hi || lo !== m_lo) begin
            n_fail++;
            $display("FAIL ignored_start_run busy=%b hi=%h lo=%h want 1 %h %h", busy, hi, lo, m_hi, m_lo);
        end
        start = 1'b0;
        repeat (MC - 2) @(posedge clk);
        #1;
        n_chk++;
        if (busy !== 1'b0 || hi !== ehi || lo !== elo) begin
            n_fail++;
            $display("FAIL ignored_start_commit busy=%b hi=%h lo=%h want 0 %h %h", busy, hi, lo, ehi, elo);
        end
        m_hi = ehi; m_lo = elo;
        repeat (MC + 1) @(posedge clk);
        #1;
        n_chk++;
        if (busy !== 1'b0 || hi !== m_hi || lo !== m_lo) begin
            n_fail++;
            $display("FAIL ignored_start_late busy=%b hi=%h lo=%h want 0 %h %h", busy, hi, lo, m_hi, m_lo);
        end
    endtask

    task automatic test_cancel();
        logic [31:0] ehi, elo;
        start = 1'b1; cancel = 1'b1; op = 3'd0; a = 32'd5; b = 32'd9;
        @(posedge clk); #1;
        start = 1'b0; cancel = 1'b0;
        n_chk++;
        if (busy !== 1'b0 || hi !== m_hi || lo !== m_lo) begin
            n_fail++;
            $display("FAIL cancel_start busy=%b hi=%h lo=%h want 0 %h %h", busy, hi, lo, m_hi, m_lo);
        end
        model(3'd2, 32'd100, 32'hFFFFFFF9, ehi, elo);
        start = 1'b1; op = 3'd2; a = 32'd100; b = 32'hFFFFFFF9;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        cancel = 1'b1;
        @(posedge clk); #1;
        cancel = 1'b0;
        n_chk++;
        if (busy !== 1'b1 || hi !== m_hi || lo !== m_lo) begin
            n_fail++;
            $display("FAIL cancel_mid busy=%b hi=%h lo=%h want 1 %h %h", busy, hi, lo, m_hi, m_lo);
        end
        repeat (DC - 3) @(posedge clk);
        #1;
        n_chk++;
        if (busy !== 1'b0 || hi !== ehi || lo !== elo) begin
            n_fail++;
            $display("FAIL cancel_commit busy=%b hi=%h lo=%h want 0 %h %h", busy, hi, lo, ehi, elo);
        end
        m_hi = ehi; m_lo = elo;
    endtask

    task automatic test_reset_mid();
        start = 1'b1; op = 3'd2; a = 32'd1234567; b = 32'd89;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        m_hi = '0; m_lo = '0;
        n_chk++;
        if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_mid busy=%b hi=%h lo=%h want 0 0 0", busy, hi, lo);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < DC + 2; c++) begin
            @(posedge clk); #1;
            n_chk++;
            if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_no_commit cyc=%0d busy=%b hi=%h lo=%h want 0 0 0", c, busy, hi, lo);
            end
        end
    endtask

    initial begin
        test_reset();
        test_arith(5, 1'b1, 1'b0);
        test_arith(30, 1'b0, 1'b0);
        test_arith(20, 1'b0, 1'b1);
        test_mthi_mtlo();
        test_ignored_start();
        test_cancel();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
